// File: rtl/load_store_unit_if.sv
// load_store_unit_if: data-memory bus between the load/store unit and data memory.
//   master (LSU)   : drives mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
//   slave  (memory): drives mem_ready, mem_rdata
// mem_ready marks the cycle a write is accepted or read data is returned;
// mem_rdata is only meaningful when mem_ready && !mem_we.
interface load_store_unit_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int XLEN       = 32
);
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [XLEN-1:0]       mem_wdata;
    logic [3:0]            mem_wstrb;
    logic                  mem_ready;
    logic [XLEN-1:0]       mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: data-memory access stage behind the decoder.
// Accepts a load/store in IDLE, issues one request on the memory bus, waits
// for mem_ready, then spends one DONE cycle (stall released, load_valid for
// loads) before returning to IDLE.
//
// Ports:
//   clk, rst            core clock, synchronous active-high reset
//   dmem_read/write     decoder strobes for the current instruction
//   funct3              size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   addr, store_data    effective byte address, rs2 value
//   stall               hold the core (combinational on acceptance)
//   load_data           extended load result, held until the next load
//   load_valid, fault   single-cycle registered pulses
//   mem                 memory bus (load_store_unit_if.master)
//
// Build option: LSU_FAULT_EN
//   defined   - misaligned / illegal / double-strobe accesses are refused
//               and reported with a one-cycle fault pulse.
//   undefined - fault stays 0; every access is performed after forcing it
//               legal (misaligned offset bits cleared, bad funct3 -> W,
//               both strobes -> read).
// Only XLEN = 32 is supported.
module load_store_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int XLEN       = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dmem_read,
    input  logic                  dmem_write,
    input  logic [2:0]            funct3,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [XLEN-1:0]       store_data,
    output logic                  stall,
    output logic [XLEN-1:0]       load_data,
    output logic                  load_valid,
    output logic                  fault,
    load_store_unit_if.master     mem
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    typedef struct packed {
        logic                  we;
        logic [2:0]            f3;
        logic [1:0]            off;   // byte offset used for lane selection
        logic [ADDR_WIDTH-3:0] word;
        logic [XLEN-1:0]       data;
    } req_t;

    state_t state;
    req_t   r;

    logic       any_strobe, is_store, f3_ok, illegal, accept;
    logic [2:0] f3_n;
    logic [1:0] off_n;

    // Request classification. Normalisation is always applied: in the
    // fault build an accepted access is already legal, so it is a no-op.
    always_comb begin
        any_strobe = dmem_read | dmem_write;
        is_store   = dmem_write & ~dmem_read;  // both strobes decode as a read
        if (is_store)
            f3_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
        else
            f3_ok = (funct3 != 3'b011) && (funct3[2:1] != 2'b11);
        f3_n = f3_ok ? funct3 : 3'b010;
        case (f3_n[1:0])
            2'b00:   off_n = addr[1:0];
            2'b01:   off_n = {addr[1], 1'b0};
            default: off_n = 2'b00;
        endcase
`ifdef LSU_FAULT_EN
        illegal = (dmem_read & dmem_write) | ~f3_ok
                | ((funct3[1:0] == 2'b01) && addr[0])
                | ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
`else
        illegal = 1'b0;
`endif
        accept = (state == IDLE) && any_strobe && !illegal;
        stall  = accept || (state == REQ);
    end

    // Store lane formatting and address, all from the latched request so
    // the bus stays stable for the whole REQ phase.
    logic [XLEN-1:0] wdata;
    logic [3:0]      wstrb;
    always_comb begin
        case (r.f3[1:0])
            2'b00: begin
                wdata = {4{r.data[7:0]}};
                wstrb = 4'b0001 << r.off;
            end
            2'b01: begin
                wdata = {2{r.data[15:0]}};
                wstrb = 4'b0011 << r.off;
            end
            default: begin
                wdata = r.data;
                wstrb = 4'b1111;
            end
        endcase
    end

    assign mem.mem_we    = r.we;
    assign mem.mem_addr  = {r.word, 2'b00};
    assign mem.mem_wdata = wdata;
    assign mem.mem_wstrb = r.we ? wstrb : 4'b0000;

    // Load lane extraction and extension.
    logic [7:0]      byte_l;
    logic [15:0]     half_l;
    logic [XLEN-1:0] ld_ext;
    always_comb begin
        byte_l = 8'(mem.mem_rdata >> {r.off, 3'b000});
        half_l = 16'(mem.mem_rdata >> {r.off[1], 4'b0000});
        case (r.f3)
            3'b000:  ld_ext = {{(XLEN-8){byte_l[7]}}, byte_l};
            3'b001:  ld_ext = {{(XLEN-16){half_l[15]}}, half_l};
            3'b100:  ld_ext = {{(XLEN-8){1'b0}}, byte_l};
            3'b101:  ld_ext = {{(XLEN-16){1'b0}}, half_l};
            default: ld_ext = mem.mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            r           <= '0;
            load_data   <= '0;
            load_valid  <= 1'b0;
            fault       <= 1'b0;
            mem.mem_req <= 1'b0;
        end else begin
            load_valid <= 1'b0;
            fault      <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        r.we        <= is_store;
                        r.f3        <= f3_n;
                        r.off       <= off_n;
                        r.word      <= addr[ADDR_WIDTH-1:2];
                        r.data      <= store_data;
                        mem.mem_req <= 1'b1;
                        state       <= REQ;
                    end else if (any_strobe && illegal) begin
                        fault <= 1'b1;
                    end
                end
                REQ: begin
                    if (mem.mem_ready) begin
                        mem.mem_req <= 1'b0;
                        state       <= DONE;
                        if (!r.we) begin
                            load_data  <= ld_ext;
                            load_valid <= 1'b1;
                        end
                    end
                end
                // Strobes still held for the finishing instruction are ignored.
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed vectors with hand-computed expectations for
// load_store_unit. Exercises both builds (LSU_FAULT_EN defined or not).
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        dmem_read, dmem_write;
    logic [2:0]  funct3;
    logic [31:0] addr, store_data;
    logic        stall, load_valid, fault;
    logic [31:0] load_data;

    load_store_unit_if #(.ADDR_WIDTH(32), .XLEN(32)) mif ();

    load_store_unit dut (
        .clk        (clk),
        .rst        (rst),
        .dmem_read  (dmem_read),
        .dmem_write (dmem_write),
        .funct3     (funct3),
        .addr       (addr),
        .store_data (store_data),
        .stall      (stall),
        .load_data  (load_data),
        .load_valid (load_valid),
        .fault      (fault),
        .mem        (mif)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Observations from the last run_access call.
    int          s_stall, s_lv, s_fault, s_req;
    bit          s_stable;
    logic        q_we;
    logic [31:0] q_addr, q_wdata;
    logic [3:0]  q_wstrb;

    // Drives one instruction starting at posedge+1. Strobes stay asserted
    // until the first cycle with stall low has passed its edge (i.e. through
    // DONE), mimicking a stalled core. During REQ the raw inputs are
    // scrambled to confirm the unit works from latched values. mem_ready
    // rises on REQ cycle waits+1.
    task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] d,
                              input logic [31:0] rdata, input int waits);
        bit drop = 1'b0;
        int reqc = 0;
        dmem_read = rd; dmem_write = wr; funct3 = f3; addr = a; store_data = d;
        mif.mem_rdata = rdata; mif.mem_ready = 1'b0;
        s_stall = 0; s_lv = 0; s_fault = 0; s_stable = 1'b1;
        for (int c = 0; c < waits + 6; c++) begin
            if (drop) begin dmem_read = 1'b0; dmem_write = 1'b0; end
            #1;
            if (stall)      s_stall++;
            if (load_valid) s_lv++;
            if (fault)      s_fault++;
            if (!stall)     drop = 1'b1;
            if (mif.mem_req) begin
                if (reqc == 0) begin
                    q_we = mif.mem_we; q_addr = mif.mem_addr;
                    q_wdata = mif.mem_wdata; q_wstrb = mif.mem_wstrb;
                end else if (q_we !== mif.mem_we || q_addr !== mif.mem_addr ||
                             q_wdata !== mif.mem_wdata || q_wstrb !== mif.mem_wstrb) begin
                    s_stable = 1'b0;
                end
                reqc++;
                mif.mem_ready = (reqc > waits);
                store_data = ~d;
                addr = a ^ 32'h4;
            end else begin
                mif.mem_ready = 1'b0;
            end
            @(posedge clk); #1;
        end
        s_req = reqc;
        dmem_read = 1'b0; dmem_write = 1'b0; mif.mem_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; dmem_read = 1'b0; dmem_write = 1'b0; funct3 = 3'b000;
        addr = '0; store_data = '0; mif.mem_ready = 1'b0; mif.mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", {31'b0, stall}, 32'd0);
        chk("rst_req",   {31'b0, mif.mem_req}, 32'd0);
        chk("rst_lv",    {31'b0, load_valid}, 32'd0);
        chk("rst_fault", {31'b0, fault}, 32'd0);
        chk("rst_ldata", load_data, 32'h0);
        chk("rst_wstrb", {28'b0, mif.mem_wstrb}, 32'd0);
        rst = 1'b0;

        // Reset while a request is outstanding.
        dmem_read = 1'b1; funct3 = 3'b010; addr = 32'h40;
        #1 chk("acc_stall_comb", {31'b0, stall}, 32'd1);
        @(posedge clk); #1;
        chk("mid_req", {31'b0, mif.mem_req}, 32'd1);
        dmem_read = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("mid_rst_req",   {31'b0, mif.mem_req}, 32'd0);
        chk("mid_rst_stall", {31'b0, stall}, 32'd0);
        chk("mid_rst_lv",    {31'b0, load_valid}, 32'd0);
        @(posedge clk); #1;
        chk("mid_rst_idle", {31'b0, mif.mem_req}, 32'd0);

        // LW 0x100, ready on 2nd REQ cycle.
        run_access(1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1);
        chk("lw_addr",  q_addr, 32'h100);
        chk("lw_we",    {31'b0, q_we}, 32'd0);
        chk("lw_wstrb", {28'b0, q_wstrb}, 32'd0);
        chk("lw_stall", s_stall, 32'd3);
        chk("lw_reqc",  s_req, 32'd2);
        chk("lw_lv",    s_lv, 32'd1);
        chk("lw_data",  load_data, 32'hDEADBEEF);

        run_access(1, 0, 3'b000, 32'h103, 32'h0, 32'h80123456, 0);
        chk("lb_stall", s_stall, 32'd2);
        chk("lb_data",  load_data, 32'hFFFFFF80);
        run_access(1, 0, 3'b100, 32'h103, 32'h0, 32'h80123456, 0);
        chk("lbu_data", load_data, 32'h00000080);
        run_access(1, 0, 3'b001, 32'h102, 32'h0, 32'h80123456, 0);
        chk("lh_data",  load_data, 32'hFFFF8012);
        run_access(1, 0, 3'b101, 32'h100, 32'h0, 32'h80123456, 0);
        chk("lhu_data", load_data, 32'h00003456);

        // SH 0x202.
        run_access(0, 1, 3'b001, 32'h202, 32'h1234ABCD, 32'h0, 0);
        chk("sh_we",    {31'b0, q_we}, 32'd1);
        chk("sh_addr",  q_addr, 32'h200);
        chk("sh_wdata", q_wdata, 32'hABCDABCD);
        chk("sh_wstrb", {28'b0, q_wstrb}, 32'hC);
        chk("sh_lv",    s_lv, 32'd0);
        chk("sh_hold",  load_data, 32'h00003456);

        // SB 0x201 with ready held low for 5 REQ cycles.
        run_access(0, 1, 3'b000, 32'h201, 32'h000000EE, 32'h0, 5);
        chk("sb_wdata",  q_wdata, 32'hEEEEEEEE);
        chk("sb_wstrb",  {28'b0, q_wstrb}, 32'h2);
        chk("sb_stall",  s_stall, 32'd7);
        chk("sb_stable", {31'b0, s_stable}, 32'd1);

        run_access(0, 1, 3'b010, 32'h300, 32'hCAFEF00D, 32'h0, 0);
        chk("sw_wdata", q_wdata, 32'hCAFEF00D);
        chk("sw_wstrb", {28'b0, q_wstrb}, 32'hF);

`ifdef LSU_FAULT_EN
        run_access(1, 0, 3'b010, 32'h102, 32'h0, 32'h11223344, 0);
        chk("f_lw_req",   s_req, 32'd0);
        chk("f_lw_fault", s_fault, 32'd1);
        chk("f_lw_stall", s_stall, 32'd0);
        run_access(1, 1, 3'b000, 32'h100, 32'h0, 32'h11223344, 0);
        chk("f_both_req",   s_req, 32'd0);
        chk("f_both_fault", s_fault, 32'd1);
        run_access(1, 0, 3'b001, 32'h101, 32'h0, 32'h11223344, 0);
        chk("f_lh_fault", s_fault, 32'd1);
        run_access(0, 1, 3'b100, 32'h100, 32'h0, 32'h0, 0);
        chk("f_st_f3_fault", s_fault, 32'd1);
        chk("f_hold", load_data, 32'h00003456);
`else
        run_access(1, 0, 3'b010, 32'h102, 32'h0, 32'h11223344, 0);
        chk("n_lw_addr",  q_addr, 32'h100);
        chk("n_lw_data",  load_data, 32'h11223344);
        chk("n_lw_fault", s_fault, 32'd0);
        run_access(1, 0, 3'b001, 32'h103, 32'h0, 32'h80123456, 0);
        chk("n_lh_data", load_data, 32'hFFFF8012);
        run_access(1, 1, 3'b000, 32'h101, 32'h0, 32'h80123456, 0);
        chk("n_both_we",   {31'b0, q_we}, 32'd0);
        chk("n_both_data", load_data, 32'h00000034);
        run_access(0, 1, 3'b100, 32'h205, 32'h11223344, 32'h0, 0);
        chk("n_st_addr",  q_addr, 32'h204);
        chk("n_st_wdata", q_wdata, 32'h11223344);
        chk("n_st_wstrb", {28'b0, q_wstrb}, 32'hF);
        run_access(1, 0, 3'b011, 32'h104, 32'h0, 32'h89ABCDEF, 0);
        chk("n_ld011_data", load_data, 32'h89ABCDEF);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
